// File: rtl/alu_seq_ctrl.sv
// ALU control decoder with an iterative multiply/divide sequencer.
// Decodes ALUOp/Funct3/Funct7/IsImm into a 5-bit ALU select every cycle.
// For M-extension encodings it runs a WIDTH-cycle shift-add or restoring
// divide on operand magnitudes, then holds the result until it is taken.
module alu_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter bit M_EXT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       ALUOp,
    input  logic [6:0]       Funct7,
    input  logic [2:0]       Funct3,
    input  logic             IsImm,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [4:0]       Operation,
    output logic             illegal,
    output logic             stall,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result
);

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_SLTU = 5'b00101;
    localparam logic [4:0] OP_BLTU = 5'b00110;
    localparam logic [4:0] OP_BGEU = 5'b00111;
    localparam logic [4:0] OP_BEQ  = 5'b01000;
    localparam logic [4:0] OP_BNE  = 5'b01001;
    localparam logic [4:0] OP_BLT  = 5'b01010;
    localparam logic [4:0] OP_BGE  = 5'b01011;
    localparam logic [4:0] OP_SLL  = 5'b01100;
    localparam logic [4:0] OP_SRL  = 5'b01101;
    localparam logic [4:0] OP_SLT  = 5'b01110;
    localparam logic [4:0] OP_SRA  = 5'b01111;

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t           state, next_state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi;        // product high half / partial remainder
    logic [WIDTH-1:0] lo;        // multiplier bits / dividend-then-quotient
    logic [WIDTH-1:0] bop;       // multiplicand / divisor magnitude
    logic [WIDTH-1:0] a_orig;    // raw dividend, returned by REM on divide-by-zero
    logic [2:0]       fn;
    logic             sgn_a, sgn_b, div0;

    logic [4:0]       op_d;
    logic             ill_d;
    logic             m_op, start;
    logic             signed_a, signed_b, sa_in, sb_in;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0] hi_step, lo_step;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix, final_res;
    logic             neg;

    // Decode the instruction tuple into an ALU select; illegal tuples fall back to ADD.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        op_d  = OP_ADD;
        ill_d = 1'b0;
        case (ALUOp)
            2'b01: begin
                case (Funct3)
                    3'b000:  op_d = OP_BEQ;
                    3'b001:  op_d = OP_BNE;
                    3'b100:  op_d = OP_BLT;
                    3'b101:  op_d = OP_BGE;
                    3'b110:  op_d = OP_BLTU;
                    3'b111:  op_d = OP_BGEU;
                    default: ill_d = 1'b1;
                endcase
            end
            2'b10: begin
                if (IsImm || Funct7 == 7'b0000000) begin
                    case (Funct3)
                        3'b000:  op_d = OP_ADD;
                        3'b001:  op_d = OP_SLL;
                        3'b010:  op_d = OP_SLT;
                        3'b011:  op_d = OP_SLTU;
                        3'b100:  op_d = OP_XOR;
                        3'b101:  op_d = (IsImm && Funct7[5]) ? OP_SRA : OP_SRL;
                        3'b110:  op_d = OP_OR;
                        default: op_d = OP_AND;
                    endcase
                    // Immediate shift-left only allows a zero upper field.
                    if (IsImm && Funct3 == 3'b001 && Funct7 != 7'b0000000)
                        ill_d = 1'b1;
                end else if (Funct7 == 7'b0100000) begin
                    if (Funct3 == 3'b000)
                        op_d = OP_SUB;
                    else if (Funct3 == 3'b101)
                        op_d = OP_SRA;
                    else
                        ill_d = 1'b1;
                end else if (Funct7 == 7'b0000001 && M_EXT) begin
                    op_d = {2'b10, Funct3};
                end else begin
                    ill_d = 1'b1;
                end
            end
            default: op_d = OP_ADD;
        endcase
        if (ill_d)
            op_d = OP_ADD;
    end

    assign Operation = op_d;
    assign illegal   = ill_d;
    assign m_op      = !ill_d && op_d[4];
    assign start     = (state == S_IDLE) && in_valid && m_op;

    // Operand signedness and magnitudes captured at the accepting edge.
    always_comb begin
        signed_a = !(Funct3 inside {3'b011, 3'b101, 3'b111});
        signed_b = Funct3 inside {3'b000, 3'b001, 3'b100, 3'b110};
        sa_in    = signed_a && SrcA[WIDTH-1];
        sb_in    = signed_b && SrcB[WIDTH-1];
        mag_a    = sa_in ? -SrcA : SrcA;
        mag_b    = sb_in ? -SrcB : SrcB;
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, bop} : {(WIDTH+1){1'b0}});
        div_shift = {hi, lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, bop};
        if (state == S_DIV) begin
            if (!div_diff[WIDTH]) begin
                hi_step = div_diff[WIDTH-1:0];
                lo_step = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_step = div_shift[WIDTH-1:0];
                lo_step = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_step = mul_sum[WIDTH:1];
            lo_step = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end

    // Apply signs to the magnitude result of the final step and pick the requested half.
    always_comb begin
        neg      = sgn_a ^ sgn_b;
        prod     = {hi_step, lo_step};
        prod_fix = neg ? -prod : prod;
        quo_fix  = div0 ? {WIDTH{1'b1}} : (neg ? -lo_step : lo_step);
        rem_fix  = div0 ? a_orig : (sgn_a ? -hi_step : hi_step);
        case (fn)
            3'b000:                 final_res = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         final_res = quo_fix;
            default:                final_res = rem_fix;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // Sequencer next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = Funct3[2] ? S_DIV : S_MUL;
            S_MUL,
            S_DIV:   if (cnt == '0) next_state = S_DONE;
            S_DONE:  if (out_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Handshake and pipeline-hold outputs derived from the state.
    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
        stall     = start || (state != S_IDLE);
    end

    // Operand capture, iteration registers and result register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: datapath registers are reset too, so a discarded operation leaves no residue visible on Result.
        if (reset) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            bop    <= '0;
            a_orig <= '0;
            fn     <= '0;
            sgn_a  <= 1'b0;
            sgn_b  <= 1'b0;
            div0   <= 1'b0;
            Result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt    <= CW'(WIDTH - 1);
                        hi     <= '0;
                        fn     <= Funct3;
                        sgn_a  <= sa_in;
                        sgn_b  <= sb_in;
                        a_orig <= SrcA;
                        div0   <= (SrcB == '0);
                        if (Funct3[2]) begin
                            lo  <= mag_a;
                            bop <= mag_b;
                        end else begin
                            lo  <= mag_b;
                            bop <= mag_a;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    hi <= hi_step;
                    lo <= lo_step;
                    if (cnt == '0)
                        Result <= final_res;
                    else
                        cnt <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: an edge-counting transaction model
// plus arithmetic reference, compared every falling edge, and literal pins.
module tb_alu_seq_ctrl;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic [1:0]       ALUOp;
    logic [6:0]       Funct7;
    logic [2:0]       Funct3;
    logic             IsImm;
    logic [WIDTH-1:0] SrcA, SrcB;
    logic             in_valid, in_ready;
    logic [4:0]       Operation;
    logic             illegal, stall, out_valid, out_ready;
    logic [WIDTH-1:0] Result;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    alu_seq_ctrl #(.WIDTH(WIDTH), .M_EXT(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .ALUOp     (ALUOp),
        .Funct7    (Funct7),
        .Funct3    (Funct3),
        .IsImm     (IsImm),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .illegal   (illegal),
        .stall     (stall),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decode tables indexed by Funct3.
    localparam logic [4:0] BR_TAB [8] = '{5'b01000, 5'b01001, 5'b00010, 5'b00010,
                                          5'b01010, 5'b01011, 5'b00110, 5'b00111};
    localparam logic [4:0] AR_TAB [8] = '{5'b00010, 5'b01100, 5'b01110, 5'b00101,
                                          5'b00100, 5'b01101, 5'b00001, 5'b00000};

    // Returns {illegal, operation} for a tuple.
    function automatic logic [5:0] ref_decode(input logic [1:0] aop, input logic [6:0] f7,
                                              input logic [2:0] f3, input logic imm);
        logic [4:0] op;
        logic       ill;
        op  = 5'b00010;
        ill = 1'b0;
        if (aop == 2'b01) begin
            if (f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
            else op = BR_TAB[f3];
        end else if (aop == 2'b10) begin
            if (imm) begin
                op = AR_TAB[f3];
                if (f3 == 3'd5 && f7[5]) op = 5'b01111;
                if (f3 == 3'd1 && f7 != 7'd0) ill = 1'b1;
            end else if (f7 == 7'd0) begin
                op = AR_TAB[f3];
            end else if (f7 == 7'h20) begin
                if (f3 == 3'd0) op = 5'b00011;
                else if (f3 == 3'd5) op = 5'b01111;
                else ill = 1'b1;
            end else if (f7 == 7'h01) begin
                op = {2'b10, f3};
            end else begin
                ill = 1'b1;
            end
        end
        if (ill) op = 5'b00010;
        return {ill, op};
    endfunction

    // Arithmetic reference for the M operations using 64-bit integers.
    function automatic logic [31:0] m_expect(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
        longint     sa, sb, ub;
        logic [63:0] p, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    logic [5:0] exp_dec;
    assign exp_dec = ref_decode(ALUOp, Funct7, Funct3, IsImm);

    // Transaction model: idle, or busy counting edges since acceptance, then done.
    bit          m_busy, m_done;
    int          m_cnt;
    logic [31:0] m_res;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
            m_res  <= '0;
        end else if (!m_busy) begin
            if (in_valid && !exp_dec[5] && exp_dec[4]) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                m_res  <= m_expect(Funct3, SrcA, SrcB);
            end
        end else if (!m_done) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == WIDTH) m_done <= 1'b1;
        end else if (out_ready) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_operation", Operation, exp_dec[4:0]);
            check("cyc_illegal", illegal, exp_dec[5]);
            check("cyc_in_ready", in_ready, !m_busy);
            check("cyc_out_valid", out_valid, m_done);
            check("cyc_stall", stall, m_busy || (in_valid && !exp_dec[5] && exp_dec[4]));
            if (m_done) check("cyc_result", Result, m_res);
        end
    end

    task automatic run_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input int hold, output logic [31:0] r_first, output logic [31:0] r_last);
        int edges;
        ALUOp     = 2'b10;
        IsImm     = 1'b0;
        Funct7    = 7'h01;
        Funct3    = f3;
        SrcA      = a;
        SrcB      = b;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tick();
        SrcA  = a ^ 32'hDEAD_BEEF;
        SrcB  = b + 32'd3;
        edges = 0;
        while (!out_valid && edges < 200) begin
            if (edges == WIDTH - 4) in_valid = 1'b0;
            tick();
            edges++;
        end
        in_valid = 1'b0;
        check("latency", edges, WIDTH);
        r_first = Result;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_in_ready", in_ready, 1'b0);
            check("hold_stall", stall, 1'b1);
        end
        r_last    = Result;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_after_take", in_ready, 1'b1);
    endtask

    logic [31:0] r, r2;
    bit          seen_ov;
    logic [5:0]  d;

    initial begin
        reset     = 1'b1;
        ALUOp     = 2'b00;
        Funct7    = 7'd0;
        Funct3    = 3'd0;
        IsImm     = 1'b0;
        SrcA      = '0;
        SrcB      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", Result, 32'd0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_stall", stall, 1'b0);
        reset = 1'b0;
        tick();

        // Literal decode pins, then the full decode sweep.
        ALUOp = 2'b10; Funct3 = 3'd0; Funct7 = 7'h20; IsImm = 1'b0; #1;
        check("lit_sub", Operation, 5'b00011);
        IsImm = 1'b1; #1;
        check("lit_addi", Operation, 5'b00010);
        check("lit_addi_legal", illegal, 1'b0);
        ALUOp = 2'b01; Funct3 = 3'd2; #1;
        check("lit_br010_ill", illegal, 1'b1);
        check("lit_br010_op", Operation, 5'b00010);
        Funct3 = 3'd7; #1;
        check("lit_bgeu", Operation, 5'b00111);
        ALUOp = 2'b10; Funct3 = 3'd5; Funct7 = 7'h20; IsImm = 1'b1; #1;
        check("lit_srai", Operation, 5'b01111);
        Funct3 = 3'd1; Funct7 = 7'h01; #1;
        check("lit_slli_bad", illegal, 1'b1);
        IsImm = 1'b0; Funct3 = 3'd6; #1;
        check("lit_rem", Operation, 5'b10110);

        for (int aop = 0; aop < 4; aop++)
            for (int f3 = 0; f3 < 8; f3++)
                for (int f7 = 0; f7 < 128; f7++)
                    for (int imm = 0; imm < 2; imm++) begin
                        ALUOp  = aop[1:0];
                        Funct3 = f3[2:0];
                        Funct7 = f7[6:0];
                        IsImm  = imm[0];
                        #1;
                        d = ref_decode(ALUOp, Funct7, Funct3, IsImm);
                        check($sformatf("dec_op %0d/%0d/%0d/%0d", aop, f3, f7, imm), Operation, d[4:0]);
                        check($sformatf("dec_ill %0d/%0d/%0d/%0d", aop, f3, f7, imm), illegal, d[5]);
                    end
        tick();
        cmp_en = 1'b1;

        // Illegal and non-M tuples presented as valid must not start the sequencer.
        ALUOp = 2'b01; Funct3 = 3'd2; Funct7 = 7'd0; IsImm = 1'b0; in_valid = 1'b1;
        repeat (3) tick();
        check("illegal_no_start", in_ready, 1'b1);
        ALUOp = 2'b10; Funct3 = 3'd0; Funct7 = 7'h01; IsImm = 1'b1;
        repeat (3) tick();
        check("addi_no_start", in_ready, 1'b1);
        in_valid = 1'b0;
        tick();

        run_mop(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, r, r2); check("mulh_m1_m1", r, 32'h0000_0000);
        run_mop(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, r, r2); check("mulhu_max", r, 32'hFFFF_FFFE);
        run_mop(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, r, r2); check("mulhsu_min", r, 32'h8000_0000);
        run_mop(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0, r, r2);
        run_mop(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, r, r2); check("div_ovf", r, 32'h8000_0000);
        run_mop(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, r, r2); check("rem_ovf", r, 32'h0);
        run_mop(3'd5, 32'd7, 32'd0, 0, r, r2);                 check("divu_by0", r, 32'hFFFF_FFFF);
        run_mop(3'd7, 32'd7, 32'd0, 0, r, r2);                 check("remu_by0", r, 32'd7);
        run_mop(3'd4, 32'd7, 32'd0, 0, r, r2);                 check("div_by0", r, 32'hFFFF_FFFF);
        run_mop(3'd6, 32'hFFFF_FFF9, 32'd0, 0, r, r2);         check("rem_by0", r, 32'hFFFF_FFF9);
        run_mop(3'd4, 32'hFFFF_FFF9, 32'd2, 0, r, r2);         check("div_m7_2", r, 32'hFFFF_FFFD);
        run_mop(3'd6, 32'hFFFF_FFF9, 32'd2, 0, r, r2);         check("rem_m7_2", r, 32'hFFFF_FFFF);
        run_mop(3'd4, 32'd7, 32'hFFFF_FFFE, 0, r, r2);         check("div_7_m2", r, 32'hFFFF_FFFD);
        run_mop(3'd6, 32'd7, 32'hFFFF_FFFE, 0, r, r2);         check("rem_7_m2", r, 32'd1);
        run_mop(3'd7, 32'd100, 32'd7, 0, r, r2);               check("remu_100_7", r, 32'd2);
        run_mop(3'd5, 32'd100, 32'd7, 5, r, r2);
        check("hold_first", r, 32'd14);
        check("hold_last", r2, 32'd14);

        // Reset during a divide discards it.
        ALUOp = 2'b10; IsImm = 1'b0; Funct7 = 7'h01; Funct3 = 3'd4;
        SrcA = 32'd1000; SrcB = 32'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_stall", stall, 1'b0);
        check("midrst_result", Result, 32'd0);
        repeat (2) tick();
        reset   = 1'b0;
        seen_ov = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen_ov = 1'b1;
        end
        check("no_valid_after_reset", seen_ov, 1'b0);
        run_mop(3'd0, 32'd3, 32'd5, 0, r, r2); check("mul_3_5", r, 32'd15);

        tick();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
